// File: rtl/orion_mem_pkg.sv
// Shared types for the Orion memory subsystem: arbiter state, access owner,
// and the resolved RAM byte-address width also used by the memory-map logic.
package orion_mem_pkg;

   localparam int RAM_AW = 21;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   typedef enum logic {
      OWN_CPU,
      OWN_VID
   } owner_t;

endpackage

// File: rtl/orion_arb_pick.sv
// Priority pick between CPU and video: video wins unless the CPU has been
// passed over CPU_STARVE_MAX times in a row while pending.
module orion_arb_pick
   import orion_mem_pkg::*;
#(
   parameter int CPU_STARVE_MAX = 4,
   parameter int SCW            = $clog2(CPU_STARVE_MAX + 1)
) (
   input  logic           cpu_req,
   input  logic           vid_req,
   input  logic [SCW-1:0] starve_cnt,
   output logic           grant_valid,
   output owner_t         grant_owner
);

   localparam logic [SCW-1:0] STARVE_TOP = SCW'(CPU_STARVE_MAX);

   always_comb begin
      grant_valid = cpu_req | vid_req;
      grant_owner = OWN_CPU;
      if (vid_req && !(cpu_req && (starve_cnt == STARVE_TOP))) begin
         grant_owner = OWN_VID;
      end
   end

endmodule

// File: rtl/orion_ram_arbiter.sv
// Single-port system RAM arbiter: CPU and video refresh share one byte-wide RAM
// through a fixed-length IDLE -> ACCESS -> DONE sequence.
//
// state  | meaning
// IDLE   | strobes inactive, sample requests and grant one owner
// ACCESS | address/data/strobes held for SRAM_WAIT cycles, read data captured on the last
// DONE   | owner's ack high for one cycle, requests ignored
module orion_ram_arbiter
   import orion_mem_pkg::*;
#(
   parameter int SRAM_WAIT      = 1,
   parameter int CPU_STARVE_MAX = 4,
   parameter int AW             = RAM_AW
) (
   input  logic          i_clk,
   input  logic          reset_n,
   input  logic          i_cpu_req,
   input  logic          i_cpu_we,
   input  logic [AW-1:0] i_cpu_addr,
   input  logic [7:0]    i_cpu_wdata,
   output logic [7:0]    o_cpu_rdata,
   output logic          o_cpu_ack,
   output logic          o_cpu_wait_n,
   input  logic          i_vid_req,
   input  logic [AW-1:0] i_vid_addr,
   output logic [7:0]    o_vid_rdata,
   output logic          o_vid_ack,
   output logic [AW-1:0] o_ram_addr,
   output logic [7:0]    o_ram_wdata,
   input  logic [7:0]    i_ram_rdata,
   output logic          o_ram_ce_n,
   output logic          o_ram_oe_n,
   output logic          o_ram_we_n
);

   localparam int             SCW        = $clog2(CPU_STARVE_MAX + 1);
   localparam logic [SCW-1:0] STARVE_TOP = SCW'(CPU_STARVE_MAX);
   localparam logic [2:0]     WAIT_LOAD  = 3'(SRAM_WAIT - 1);

   state_t         state;
   owner_t         owner;
   logic [2:0]     wait_cnt;
   logic [SCW-1:0] starve_cnt;
   logic           grant_valid;
   owner_t         grant_owner;

   orion_arb_pick #(
      .CPU_STARVE_MAX (CPU_STARVE_MAX),
      .SCW            (SCW)
   ) u_pick (
      .cpu_req     (i_cpu_req),
      .vid_req     (i_vid_req),
      .starve_cnt  (starve_cnt),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // The only combinational output: the CPU must stall from the very cycle it requests.
   assign o_cpu_wait_n = ~(i_cpu_req & ~o_cpu_ack);

   always_ff @(posedge i_clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         owner       <= OWN_CPU;
         wait_cnt    <= '0;
         starve_cnt  <= '0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
         o_ram_ce_n  <= 1'b1;
         o_ram_oe_n  <= 1'b1;
         o_ram_we_n  <= 1'b1;
         o_cpu_rdata <= '0;
         o_vid_rdata <= '0;
         o_cpu_ack   <= 1'b0;
         o_vid_ack   <= 1'b0;
      end else begin
         o_cpu_ack <= 1'b0;
         o_vid_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (!i_cpu_req) begin
                  starve_cnt <= '0;
               end
               if (grant_valid) begin
                  owner      <= grant_owner;
                  wait_cnt   <= WAIT_LOAD;
                  o_ram_ce_n <= 1'b0;
                  state      <= ACCESS;
                  if (grant_owner == OWN_VID) begin
                     o_ram_addr <= i_vid_addr;
                     o_ram_oe_n <= 1'b0;
                     if (i_cpu_req && (starve_cnt != STARVE_TOP)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                     end
                  end else begin
                     o_ram_addr  <= i_cpu_addr;
                     o_ram_wdata <= i_cpu_wdata;
                     o_ram_oe_n  <= i_cpu_we;
                     o_ram_we_n  <= ~i_cpu_we;
                     starve_cnt  <= '0;
                  end
               end
            end
            ACCESS: begin
               if (wait_cnt == 3'd0) begin
                  if (owner == OWN_VID) begin
                     o_vid_rdata <= i_ram_rdata;
                     o_vid_ack   <= 1'b1;
                  end else begin
                     o_cpu_rdata <= i_ram_rdata;
                     o_cpu_ack   <= 1'b1;
                  end
                  o_ram_ce_n <= 1'b1;
                  o_ram_oe_n <= 1'b1;
                  o_ram_we_n <= 1'b1;
                  state      <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/orion_ram_arbiter.md
Name: orion_ram_arbiter

Overview:
- Shares the single 2 MB byte-wide system RAM between two requesters: the CPU memory path and the video refresh fetcher.
- Sits between the memory-mapping logic (page/window address already resolved to 21 bits) and the RAM array or external SRAM.
- Sequences each access through a fixed-length FSM and generates the CPU wait signal.
- Video has priority; a starvation guard bounds CPU latency.

Parameters:
- SRAM_WAIT, 1, number of ACCESS cycles per transfer (1..7).
- CPU_STARVE_MAX, 4, consecutive video grants allowed while the CPU is pending before the CPU is forced next.
- AW, 21, RAM byte address width.

Ports:
- i_clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- i_cpu_req  in  1  CPU access request, level, held until o_cpu_ack.
- i_cpu_we  in  1  1 = write, 0 = read; stable while i_cpu_req is high.
- i_cpu_addr  in  AW  CPU byte address.
- i_cpu_wdata  in  8  CPU write data.
- o_cpu_rdata  out  8  CPU read data, valid in the o_cpu_ack cycle.
- o_cpu_ack  out  1  one-cycle completion pulse.
- o_cpu_wait_n  out  1  low while i_cpu_req is high and o_cpu_ack is low.
- i_vid_req  in  1  video read request, level, held until o_vid_ack.
- i_vid_addr  in  AW  video byte address.
- o_vid_rdata  out  8  video read data, valid in the o_vid_ack cycle.
- o_vid_ack  out  1  one-cycle completion pulse.
- o_ram_addr  out  AW  RAM address.
- o_ram_wdata  out  8  RAM write data.
- i_ram_rdata  in  8  RAM read data.
- o_ram_ce_n  out  1  RAM chip enable.
- o_ram_oe_n  out  1  RAM output enable.
- o_ram_we_n  out  1  RAM write enable.

Behaviour:
- Clock and reset: clock i_clk; reset reset_n, synchronous, active-low.
- All outputs are registered except o_cpu_wait_n, which is combinational from i_cpu_req and registered o_cpu_ack.
- Reset values:
  - State IDLE.
  - o_ram_ce_n, o_ram_oe_n and o_ram_we_n = 1.
  - o_ram_addr, o_ram_wdata, o_cpu_rdata and o_vid_rdata = 0.
  - Both acks = 0.
  - Starvation counter = 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples the requests and picks an owner.
  - Video wins if i_vid_req is high, unless i_cpu_req is high and starve_cnt == CPU_STARVE_MAX, in which case the CPU wins.
  - If no request is pending, stays in IDLE.
  - On a grant, in the same edge: latches owner, address, write data and we; loads wait_cnt = SRAM_WAIT-1; drives ce_n=0, plus oe_n=0 (read) or we_n=0 (write); moves to ACCESS.
- ACCESS:
  - Address, data and strobes are held.
  - When wait_cnt == 0: captures i_ram_rdata into the owner's rdata register, raises the owner's ack, deasserts all strobes and moves to DONE.
  - Otherwise decrements wait_cnt.
- DONE:
  - One cycle, during which the ack is high.
  - Requests are not sampled, so requesters drop req after seeing ack.
  - Moves to IDLE.
- Latency: request seen in IDLE at cycle T gives ack at cycle T+SRAM_WAIT+1.
- Throughput: minimum period SRAM_WAIT+2 cycles per access.
- Video writes do not exist; a video grant always reads.
- Starvation counter width is $clog2(CPU_STARVE_MAX+1). Update rules:
  - Increments on a video grant while i_cpu_req is high.
  - Clears on a CPU grant, or in IDLE when i_cpu_req is low.
  - Saturates at CPU_STARVE_MAX.
- Simultaneous request of both in IDLE: arbitrated per the rules above; the loser stays pending and is not dropped.
- Requests that change address mid-access are ignored because values were latched at grant.
- Reset mid-access: the access is aborted, all strobes go inactive at the reset edge, no ack is issued, and a write may be partial.
- o_ram_addr and o_ram_wdata keep their last value in IDLE; only the strobes return inactive.

Decomposition:
- Shared package orion_mem_pkg:
  - State enum (IDLE, ACCESS, DONE).
  - Owner enum (OWN_CPU, OWN_VID).
  - Localparam RAM_AW = 21, reused by the memory-map logic.
- One combinational sub-module, orion_arb_pick:
  - Inputs: cpu_req, vid_req, starve_cnt.
  - Outputs: grant_valid, grant_owner.
  - Lets the verification engineer unit-test priority in isolation.

Test Plan:
- CPU read, SRAM_WAIT=1: i_cpu_req with addr 0x04000 rises at cycle 0, RAM holds 0xA5 → oe_n low in cycle 1, o_cpu_ack and o_cpu_rdata=0xA5 in cycle 2, o_cpu_wait_n low in cycles 0-1.
- CPU write 0x3C to 0x1FFFFF → we_n low for exactly SRAM_WAIT cycles with addr 0x1FFFFF; a subsequent read returns 0x3C.
- Both requests rise at cycle 0 → video acked at cycle 2, CPU granted at cycle 3 and acked at cycle 5.
- i_vid_req held high continuously, CPU pending, CPU_STARVE_MAX=4 → exactly 4 video acks, then a CPU ack, then video resumes.
- SRAM_WAIT=3, lone CPU read → ack 4 cycles after request; strobes active for 3 cycles; back-to-back requests spaced 5 cycles apart.
- reset_n low during ACCESS of a video read → strobes inactive next edge, no o_vid_ack, state IDLE, starve_cnt = 0.
